cpu_step_controller: RTL and testbench

//  Sits directly downstream of the frequency divider. Converts the divided slow

---
 rtl/cpu_step_controller.sv | 168 ++++++++++++++++
 tb/tb_cpu_step_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller.sv
// ----------------------------------------------------------------------------
// cpu_step_controller
//
// Purpose:
//   Turns the divided slow clock into single-cycle CPU clock-enable pulses in
//   the i_clkin domain and provides run / single-step / halt control for the
//   microprocessor core. i_slow_clk is sampled as data (synchronised and
//   edge-detected), never used as a clock.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a step button change is accepted (1..255)
//   CNT_W            width of o_step_count
//
// Ports:
//   i_clkin       system clock, sole clock of the block
//   i_rst         synchronous active-high reset
//   i_slow_clk    divided clock from the frequency divider (asynchronous, sampled)
//   i_run_sw      raw run switch, 1 = free-run
//   i_step_btn    raw bouncy step button, rising press = one step
//   i_halt_req    halt request from the CPU core (i_clkin domain, level)
//   o_cpu_en      registered one-cycle enable pulse to the CPU core
//   o_state       00 IDLE, 01 RUN, 10 STEP_WAIT, 11 HALTED
//   o_step_count  number of o_cpu_en pulses issued, wraps
// ----------------------------------------------------------------------------
module cpu_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             i_clkin,
    input  logic             i_rst,
    input  logic             i_slow_clk,
    input  logic             i_run_sw,
    input  logic             i_step_btn,
    input  logic             i_halt_req,
    output logic             o_cpu_en,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_step_count
);

    localparam logic [1:0] StIdle     = 2'b00;
    localparam logic [1:0] StRun      = 2'b01;
    localparam logic [1:0] StStepWait = 2'b10;
    localparam logic [1:0] StHalted   = 2'b11;

    localparam logic [7:0]       DebLast = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // Synchronisers
    logic r_slow_s1, r_slow_s2, r_slow_s3;
    logic r_run_s1, r_run_s2;
    logic r_btn_s1, r_btn_s2;

    // Debounce
    logic [7:0] r_deb_cnt;
    logic       r_deb_level;

    // Control
    logic [1:0]       r_state;
    logic             r_cpu_en;
    logic [CNT_W-1:0] r_step_count;

    logic       w_tick;
    logic       w_btn_mismatch;
    logic       w_deb_flip;
    logic       w_step_req;
    logic [1:0] w_state_d;
    logic       w_cpu_en_d;

    // One tick per slow clock rising edge; falling edges never qualify.
    assign w_tick = r_slow_s2 & ~r_slow_s3;

    // The level flips on the last of DEBOUNCE_CYCLES consecutive mismatching cycles.
    assign w_btn_mismatch = r_btn_s2 ^ r_deb_level;
    assign w_deb_flip     = w_btn_mismatch && (r_deb_cnt == DebLast);
    // Flip towards 1 is the 0->1 transition of the debounced level.
    assign w_step_req     = w_deb_flip & r_btn_s2;

    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_slow_s1   <= 1'b0;
            r_slow_s2   <= 1'b0;
            r_slow_s3   <= 1'b0;
            r_run_s1    <= 1'b0;
            r_run_s2    <= 1'b0;
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_deb_cnt   <= 8'd0;
            r_deb_level <= 1'b0;
        end else begin
            r_slow_s1 <= i_slow_clk;
            r_slow_s2 <= r_slow_s1;
            r_slow_s3 <= r_slow_s2;
            r_run_s1  <= i_run_sw;
            r_run_s2  <= r_run_s1;
            r_btn_s1  <= i_step_btn;
            r_btn_s2  <= r_btn_s1;
            if (w_btn_mismatch) begin
                if (w_deb_flip) begin
                    r_deb_level <= r_btn_s2;
                    r_deb_cnt   <= 8'd0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 8'd1;
                end
            end else begin
                r_deb_cnt <= 8'd0;
            end
        end
    end

    // Priority: halt_req > run_s > step_req.
    always_comb begin
        w_state_d  = r_state;
        w_cpu_en_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_halt_req) begin
                    w_state_d = StHalted;
                end else if (r_run_s2) begin
                    w_state_d = StRun;
                end else if (w_step_req) begin
                    w_state_d = StStepWait;
                end
            end
            StRun: begin
                if (i_halt_req) begin
                    w_state_d = StHalted;
                end else if (!r_run_s2) begin
                    w_state_d = StIdle;
                end else begin
                    w_cpu_en_d = w_tick;
                end
            end
            StStepWait: begin
                if (i_halt_req) begin
                    w_state_d = StHalted;
                end else if (w_tick) begin
                    w_cpu_en_d = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            StHalted: begin
                w_state_d = StHalted;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cpu_en     <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cpu_en <= w_cpu_en_d;
            if (w_cpu_en_d) begin
                r_step_count <= r_step_count + CntOne;
            end
        end
    end

    assign o_cpu_en     = r_cpu_en;
    assign o_state      = r_state;
    assign o_step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
module tb_cpu_step_controller;

    logic        clk;
    logic        rst;
    logic        slow_clk;
    logic        run_sw;
    logic        step_btn;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] step_count;
    logic        cpu_en4;
    logic [1:0]  state4;
    logic [3:0]  step_count4;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int rise_cnt = 0;
    int last_rise_cyc = 0;
    int pulses = 0;
    int first_pulse_cyc = 0;
    int last_pulse_cyc = 0;
    int dbl = 0;
    int badlat = 0;
    int dut_diff = 0;
    logic prev_en = 1'b0;
    int p_save;

    cpu_step_controller u_dut (
        .i_clkin      (clk),
        .i_rst        (rst),
        .i_slow_clk   (slow_clk),
        .i_run_sw     (run_sw),
        .i_step_btn   (step_btn),
        .i_halt_req   (halt_req),
        .o_cpu_en     (cpu_en),
        .o_state      (state),
        .o_step_count (step_count)
    );

    cpu_step_controller #(.CNT_W(4)) u_dut4 (
        .i_clkin      (clk),
        .i_rst        (rst),
        .i_slow_clk   (slow_clk),
        .i_run_sw     (run_sw),
        .i_step_btn   (step_btn),
        .i_halt_req   (halt_req),
        .o_cpu_en     (cpu_en4),
        .o_state      (state4),
        .o_step_count (step_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: toggles every 26 clkin cycles, offset away from both clock edges.
    initial begin
        slow_clk = 1'b0;
        #2;
        forever begin
            #260 slow_clk = ~slow_clk;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge slow_clk) begin
        rise_cnt      = rise_cnt + 1;
        last_rise_cyc = cyc;
    end

    // Pulse monitor, sampled 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (cpu_en) begin
            pulses = pulses + 1;
            if (pulses == 1) first_pulse_cyc = cyc;
            last_pulse_cyc = cyc;
            if (prev_en) dbl = dbl + 1;
            if (cyc - last_rise_cyc != 3) badlat = badlat + 1;
        end
        if (cpu_en !== cpu_en4 || state !== state4) dut_diff = dut_diff + 1;
        prev_en = cpu_en;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the first negedge after a slow_clk rise, bounded.
    task automatic wait_rise();
        int r;
        r = rise_cnt;
        for (int i = 0; i < 60 && rise_cnt == r; i++) @(negedge clk);
        check("rise_seen", int'(rise_cnt != r), 1);
    endtask

    // Enter the low phase of slow_clk, about 22 cycles before the next rise.
    task automatic to_low_phase();
        wait_rise();
        cycles(30);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_en"}, int'(cpu_en), 0);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_cnt"}, int'(step_count), 0);
        check({tag, "_cnt4"}, int'(step_count4), 0);
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic press(input int n);
        step_btn = 1'b1;
        cycles(n);
        step_btn = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_req = 1'b0;
        cycles(3);
        check("rst_state", int'(state), 0);
        check("rst_en", int'(cpu_en), 0);
        check("rst_cnt", int'(step_count), 0);
        rst = 1'b0;

        // Free run across 10 slow_clk rises.
        to_low_phase();
        run_sw = 1'b1;
        pulses = 0;
        cycles(5);
        check("run_state", int'(state), 1);
        repeat (10) wait_rise();
        cycles(5);
        check("run_pulses", pulses, 10);
        check("run_cnt", int'(step_count), 10);
        check("run_cnt4", int'(step_count4), 10);
        check("run_span", last_pulse_cyc - first_pulse_cyc, 9 * 52);
        run_sw = 1'b0;
        cycles(3);
        check("run_off_state", int'(state), 0);
        repeat (2) wait_rise();
        cycles(5);
        check("run_off_pulses", pulses, 10);

        // Single step.
        to_low_phase();
        press(10);
        check("step_wait_state", int'(state), 2);
        check("step_wait_nopulse", pulses, 10);
        wait_rise();
        cycles(5);
        check("step_pulses", pulses, 11);
        check("step_state", int'(state), 0);
        check("step_cnt", int'(step_count), 11);

        // 2-cycle glitch is filtered out.
        to_low_phase();
        press(2);
        cycles(10);
        check("glitch_state", int'(state), 0);
        wait_rise();
        cycles(5);
        check("glitch_pulses", pulses, 11);

        // Three presses.
        repeat (3) begin
            to_low_phase();
            press(10);
            wait_rise();
            cycles(5);
        end
        check("press3_cnt", int'(step_count), 14);
        check("press3_pulses", pulses, 14);

        // Halt in the same cycle as a tick.
        to_low_phase();
        run_sw = 1'b1;
        cycles(5);
        check("halt_pre_state", int'(state), 1);
        wait_rise();
        @(negedge clk);
        halt_req = 1'b1;
        cycles(5);
        halt_req = 1'b0;
        check("halt_state", int'(state), 3);
        check("halt_nopulse", pulses, 14);
        run_sw = 1'b0;
        cycles(3);
        run_sw = 1'b1;
        cycles(3);
        press(10);
        repeat (2) wait_rise();
        cycles(5);
        check("halt_hold_state", int'(state), 3);
        check("halt_hold_pulses", pulses, 14);
        run_sw = 1'b0;
        do_reset("halt_rst");
        cycles(3);
        check("halt_exit_state", int'(state), 0);

        // Wrap of the 4-bit counter over 17 pulses.
        to_low_phase();
        run_sw = 1'b1;
        pulses = 0;
        repeat (15) wait_rise();
        cycles(5);
        check("wrap_cnt4_15", int'(step_count4), 15);
        wait_rise();
        cycles(5);
        check("wrap_cnt4_0", int'(step_count4), 0);
        check("wrap_cnt16", int'(step_count), 16);
        wait_rise();
        cycles(5);
        check("wrap_cnt4_1", int'(step_count4), 1);
        check("wrap_cnt16_17", int'(step_count), 17);

        // Reset mid-activity, landing on the tick cycle.
        p_save = pulses;
        wait_rise();
        @(negedge clk);
        do_reset("mid_rst");
        run_sw = 1'b0;
        cycles(5);
        check("mid_rst_pulses", pulses, p_save);
        check("mid_rst_state", int'(state), 0);

        // Reset during STEP_WAIT discards the step.
        to_low_phase();
        press(10);
        check("sw_rst_pre_state", int'(state), 2);
        do_reset("sw_rst");
        repeat (3) wait_rise();
        cycles(5);
        check("sw_rst_pulses", pulses, p_save);
        check("sw_rst_state", int'(state), 0);
        check("sw_rst_cnt", int'(step_count), 0);

        check("no_double_pulse", dbl, 0);
        check("tick_latency", badlat, 0);
        check("dut_agree", dut_diff, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
